// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register with operand select and RAW forwarding (optional: ALU_FWD_EN)
// Without ALU_FWD_EN the exmem_*/memwb_* inputs are ignored and operands come from the latched values.
module id_ex_operand_stage #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [REGW-1:0]  in_rs1,
    input  logic [REGW-1:0]  in_rs2,
    input  logic [REGW-1:0]  in_rd,
    input  logic [WIDTH-1:0] in_rs1_val,
    input  logic [WIDTH-1:0] in_rs2_val,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_use_imm,
    input  logic             in_sub,
    input  logic             flush,
    input  logic             exmem_wen,
    input  logic [REGW-1:0]  exmem_rd,
    input  logic [WIDTH-1:0] exmem_val,
    input  logic             memwb_wen,
    input  logic [REGW-1:0]  memwb_rd,
    input  logic [WIDTH-1:0] memwb_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_ctrl,
    output logic [REGW-1:0]  out_rd
);

    logic             valid_q;
    logic [REGW-1:0]  rs1_q;
    logic [REGW-1:0]  rs2_q;
    logic [REGW-1:0]  rd_q;
    logic [WIDTH-1:0] rs1_val_q;
    logic [WIDTH-1:0] rs2_val_q;
    logic [WIDTH-1:0] imm_q;
    logic             use_imm_q;
    logic             sub_q;

    logic [WIDTH-1:0] fwd_rs1;
    logic [WIDTH-1:0] fwd_rs2;
    logic             take;

`ifdef ALU_FWD_EN
    // EX/MEM is younger than MEM/WB, so it wins; x0 is hardwired and never forwarded.
    function automatic logic [WIDTH-1:0] fwd_sel(input logic [REGW-1:0]  src,
                                                 input logic [WIDTH-1:0] stored);
        logic [WIDTH-1:0] res;
        res = stored;
        if (src != '0) begin
            if (exmem_wen && (exmem_rd == src)) begin
                res = exmem_val;
            end else if (memwb_wen && (memwb_rd == src)) begin
                res = memwb_val;
            end
        end
        return res;
    endfunction

    assign fwd_rs1 = fwd_sel(rs1_q, rs1_val_q);
    assign fwd_rs2 = fwd_sel(rs2_q, rs2_val_q);
`else
    logic unused_fwd_inputs;

    assign fwd_rs1 = rs1_val_q;
    assign fwd_rs2 = rs2_val_q;
    assign unused_fwd_inputs = ^{exmem_wen, exmem_rd, exmem_val,
                                 memwb_wen, memwb_rd, memwb_val, rs1_q, rs2_q};
`endif

    assign in_ready = !valid_q || out_ready;
    assign take     = in_valid && in_ready;

    // The hold branch rewrites the operands with their forwarded values so a
    // producer that retires while EX is stalled is captured before it disappears.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            sub_q     <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (take) begin
            valid_q   <= 1'b1;
            rs1_q     <= in_rs1;
            rs2_q     <= in_rs2;
            rd_q      <= in_rd;
            rs1_val_q <= in_rs1_val;
            rs2_val_q <= in_rs2_val;
            imm_q     <= in_imm;
            use_imm_q <= in_use_imm;
            sub_q     <= in_sub;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end else begin
            rs1_val_q <= fwd_rs1;
            rs2_val_q <= fwd_rs2;
        end
    end

    assign out_valid = valid_q;
    assign alu_a     = fwd_rs1;
    assign alu_b     = use_imm_q ? imm_q : fwd_rs2;
    assign alu_ctrl  = sub_q;
    assign out_rd    = rd_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage (honours ALU_FWD_EN)
module tb_id_ex_operand_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm;
    logic        in_use_imm, in_sub, flush;
    logic        exmem_wen, memwb_wen;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_val, memwb_val;
    logic        out_valid, out_ready;
    logic [31:0] alu_a, alu_b;
    logic        alu_ctrl;
    logic [4:0]  out_rd;

    int n_checks;
    int n_fail;

    // Reference model: the instruction currently held by the stage.
    logic        m_valid;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_v1, m_v2, m_imm;
    logic        m_use, m_sub;

    id_ex_operand_stage #(.WIDTH(32), .REGW(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_sub(in_sub), .flush(flush),
        .exmem_wen(exmem_wen), .exmem_rd(exmem_rd), .exmem_val(exmem_val),
        .memwb_wen(memwb_wen), .memwb_rd(memwb_rd), .memwb_val(memwb_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .out_rd(out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_fwd(input logic [4:0] s, input logic [31:0] stored);
`ifdef ALU_FWD_EN
        if (s != 5'd0 && exmem_wen && exmem_rd == s) return exmem_val;
        if (s != 5'd0 && memwb_wen && memwb_rd == s) return memwb_val;
`endif
        return stored;
    endfunction

    function automatic logic [31:0] exp_a();
        return model_fwd(m_rs1, m_v1);
    endfunction

    function automatic logic [31:0] exp_b();
        return m_use ? m_imm : model_fwd(m_rs2, m_v2);
    endfunction

    // Advance one clock; the model sees the same pre-edge inputs the DUT saw.
    task automatic tick();
        logic [31:0] f1, f2;
        logic        rdy;
        @(posedge clk);
        f1  = model_fwd(m_rs1, m_v1);
        f2  = model_fwd(m_rs2, m_v2);
        rdy = !m_valid || out_ready;
        if (reset) begin
            m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
            m_v1 = 0; m_v2 = 0; m_imm = 0; m_use = 0; m_sub = 0;
        end else if (flush) begin
            m_valid = 0;
        end else if (in_valid && rdy) begin
            m_valid = 1; m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd;
            m_v1 = in_rs1_val; m_v2 = in_rs2_val; m_imm = in_imm;
            m_use = in_use_imm; m_sub = in_sub;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end else begin
            m_v1 = f1;
            m_v2 = f2;
        end
        #2;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                         input logic use_imm, input logic sub);
        in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rs1_val = v1; in_rs2_val = v2; in_imm = imm;
        in_use_imm = use_imm; in_sub = sub;
    endtask

    task automatic test_reset();
        reset = 1; tick(); tick(); reset = 0; #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        n_checks++; if (alu_a !== 32'd0) begin n_fail++; $display("FAIL reset_a got=%h want=0", alu_a); end
        n_checks++; if (alu_b !== 32'd0) begin n_fail++; $display("FAIL reset_b got=%h want=0", alu_b); end
        n_checks++; if (alu_ctrl !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl got=%0b want=0", alu_ctrl); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0b want=1", in_ready); end
        n_checks++; if (out_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd got=%0d want=0", out_rd); end
    endtask

    task automatic test_add_itype();
        out_ready = 1;
        drive(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0);
        tick(); in_valid = 0; #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got=%0b want=1", out_valid); end
        n_checks++; if (alu_a !== 32'd5) begin n_fail++; $display("FAIL add_a got=%h want=5", alu_a); end
        n_checks++; if (alu_b !== 32'd7) begin n_fail++; $display("FAIL add_b got=%h want=7", alu_b); end
        n_checks++; if (alu_ctrl !== 1'b0) begin n_fail++; $display("FAIL add_ctrl got=%0b want=0", alu_ctrl); end
        n_checks++; if (out_rd !== 5'd3) begin n_fail++; $display("FAIL add_rd got=%0d want=3", out_rd); end
        drive(5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'hFFFF_FFFC, 1'b1, 1'b0);
        tick(); in_valid = 0; #1;
        n_checks++; if (alu_b !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL itype_b got=%h want=fffffffc", alu_b); end
        n_checks++; if (out_rd !== 5'd4) begin n_fail++; $display("FAIL itype_rd got=%0d want=4", out_rd); end
        tick(); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got=%0b want=0", out_valid); end
    endtask

    task automatic test_fwd_priority();
        logic [31:0] want;
        out_ready = 0;
        drive(5'd3, 5'd0, 5'd8, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
        tick(); in_valid = 0;
        exmem_wen = 1; exmem_rd = 5'd3; exmem_val = 32'h10;
        memwb_wen = 1; memwb_rd = 5'd3; memwb_val = 32'h20;
        #1;
`ifdef ALU_FWD_EN
        want = 32'h10;
`else
        want = 32'h1;
`endif
        n_checks++; if (alu_a !== want) begin n_fail++; $display("FAIL fwd_exmem got=%h want=%h", alu_a, want); end
        exmem_wen = 0; #1;
`ifdef ALU_FWD_EN
        want = 32'h20;
`else
        want = 32'h1;
`endif
        n_checks++; if (alu_a !== want) begin n_fail++; $display("FAIL fwd_memwb got=%h want=%h", alu_a, want); end
        memwb_wen = 0; out_ready = 1;
        drive(5'd0, 5'd0, 5'd9, 32'h55, 32'h0, 32'd0, 1'b0, 1'b0);
        tick(); in_valid = 0; out_ready = 0;
        exmem_wen = 1; exmem_rd = 5'd0; exmem_val = 32'h99;
        memwb_wen = 1; memwb_rd = 5'd0; memwb_val = 32'h77;
        #1;
        n_checks++; if (alu_a !== 32'h55) begin n_fail++; $display("FAIL fwd_x0 got=%h want=55", alu_a); end
        exmem_wen = 0; memwb_wen = 0; out_ready = 1;
        tick();
    endtask

    task automatic test_stall_refresh();
        logic [31:0] want_b;
        out_ready = 1;
        drive(5'd1, 5'd6, 5'd7, 32'h11, 32'h22, 32'd0, 1'b0, 1'b0);
        tick();
        drive(5'd9, 5'd10, 5'd11, 32'h99, 32'h98, 32'd0, 1'b0, 1'b1);
        out_ready = 0;
        memwb_wen = 1; memwb_rd = 5'd6; memwb_val = 32'hAB;
`ifdef ALU_FWD_EN
        want_b = 32'hAB;
`else
        want_b = 32'h22;
`endif
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got=%0b want=0", in_ready); end
        n_checks++; if (alu_b !== want_b) begin n_fail++; $display("FAIL stall_b0 got=%h want=%h", alu_b, want_b); end
        for (int c = 1; c < 3; c++) begin
            tick();
            memwb_wen = 0; #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready%0d got=%0b want=0", c, in_ready); end
            n_checks++; if (alu_b !== want_b) begin n_fail++; $display("FAIL stall_b%0d got=%h want=%h", c, alu_b, want_b); end
            n_checks++; if (alu_a !== 32'h11 || out_rd !== 5'd7 || alu_ctrl !== 1'b0)
                begin n_fail++; $display("FAIL stall_hold%0d got a=%h rd=%0d want a=11 rd=7", c, alu_a, out_rd); end
        end
        out_ready = 1; #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%0b want=1", in_ready); end
        tick(); in_valid = 0; #1;
        n_checks++; if (alu_a !== 32'h99 || alu_ctrl !== 1'b1 || out_rd !== 5'd11)
            begin n_fail++; $display("FAIL stall_next got a=%h ctrl=%0b rd=%0d want a=99 ctrl=1 rd=11", alu_a, alu_ctrl, out_rd); end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1;
        drive(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'd0, 1'b0, 1'b0);
        tick();
        drive(5'd4, 5'd5, 5'd6, 32'h4, 32'h5, 32'd0, 1'b0, 1'b1);
        flush = 1;
        tick(); flush = 0; in_valid = 0; #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%0b want=0", out_valid); end
        drive(5'd7, 5'd8, 5'd5, 32'h31, 32'h32, 32'd0, 1'b0, 1'b0);
        tick(); in_valid = 0; #1;
        n_checks++; if (out_valid !== 1'b1 || alu_a !== 32'h31 || alu_b !== 32'h32 || out_rd !== 5'd5)
            begin n_fail++; $display("FAIL flush_next got v=%0b a=%h b=%h rd=%0d want v=1 a=31 b=32 rd=5", out_valid, alu_a, alu_b, out_rd); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] av [4];
        logic [31:0] bv [4];
        av[0] = 9;  bv[0] = 4;
        av[1] = 20; bv[1] = 3;
        av[2] = 7;  bv[2] = 7;
        av[3] = 0;  bv[3] = 1;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            drive(5'd1, 5'd2, 5'(i + 12), av[i], bv[i], 32'd0, 1'b0, 1'b1);
            tick(); #1;
            n_checks++;
            if (out_valid !== 1'b1 || alu_a !== av[i] || alu_b !== bv[i] || alu_ctrl !== 1'b1 || out_rd !== 5'(i + 12))
                begin n_fail++; $display("FAIL b2b_%0d got v=%0b a=%h b=%h c=%0b rd=%0d want a=%h b=%h c=1 rd=%0d",
                      i, out_valid, alu_a, alu_b, alu_ctrl, out_rd, av[i], bv[i], i + 12); end
        end
        in_valid = 0; tick(); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%0b want=0", out_valid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset      = ($urandom_range(0, 49) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            in_valid   = $urandom_range(0, 1);
            out_ready  = ($urandom_range(0, 2) != 0);
            in_rs1     = 5'($urandom_range(0, 3));
            in_rs2     = 5'($urandom_range(0, 3));
            in_rd      = 5'($urandom_range(0, 31));
            in_rs1_val = $urandom; in_rs2_val = $urandom; in_imm = $urandom;
            in_use_imm = $urandom_range(0, 1); in_sub = $urandom_range(0, 1);
            exmem_wen  = $urandom_range(0, 1); exmem_rd = 5'($urandom_range(0, 3)); exmem_val = $urandom;
            memwb_wen  = $urandom_range(0, 1); memwb_rd = 5'($urandom_range(0, 3)); memwb_val = $urandom;
            #1;
            n_checks++;
            if (out_valid !== m_valid || in_ready !== (!m_valid || out_ready))
                begin n_fail++; $display("FAIL rnd_hs_%0d got v=%0b r=%0b want v=%0b", c, out_valid, in_ready, m_valid); end
            if (m_valid) begin
                n_checks++;
                if (alu_a !== exp_a() || alu_b !== exp_b() || alu_ctrl !== m_sub || out_rd !== m_rd)
                    begin n_fail++; $display("FAIL rnd_op_%0d got a=%h b=%h c=%0b rd=%0d want a=%h b=%h c=%0b rd=%0d",
                          c, alu_a, alu_b, alu_ctrl, out_rd, exp_a(), exp_b(), m_sub, m_rd); end
            end
            tick();
        end
        reset = 0; flush = 0; in_valid = 0; exmem_wen = 0; memwb_wen = 0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
        m_v1 = 0; m_v2 = 0; m_imm = 0; m_use = 0; m_sub = 0;
        reset = 1; in_valid = 0; flush = 0; out_ready = 0;
        in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rs1_val = 0; in_rs2_val = 0; in_imm = 0;
        in_use_imm = 0; in_sub = 0;
        exmem_wen = 0; exmem_rd = 0; exmem_val = 0;
        memwb_wen = 0; memwb_rd = 0; memwb_val = 0;
        #1;
        test_reset();
        test_add_itype();
        test_fwd_priority();
        test_stall_refresh();
        test_flush();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-select and forwarding stage of the pipelined RISC-V core.
- Latches decoded instructions from ID and resolves RAW hazards from EX/MEM and MEM/WB.
- Drives the 32-bit EX adder's a, b and ctrl (0 = a+b, 1 = a+~b+1) under a valid/ready handshake, with stall and flush.

Parameters:
- WIDTH, 32, datapath width of operands and adder.
- REGW, 5, register-index width (x0..x31).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  ID presents an instruction
- in_ready  output  1  stage can accept this cycle
- in_rs1  input  REGW  source-1 index
- in_rs2  input  REGW  source-2 index
- in_rd  input  REGW  destination index
- in_rs1_val  input  WIDTH  register-file read, port 1
- in_rs2_val  input  WIDTH  register-file read, port 2
- in_imm  input  WIDTH  sign-extended immediate
- in_use_imm  input  1  1: operand b = imm (I-type)
- in_sub  input  1  1: subtract (SUB, BEQ/BNE compare)
- flush  input  1  kill held and incoming instruction (branch taken)
- exmem_wen  input  1  EX/MEM instruction writes rd
- exmem_rd  input  REGW  EX/MEM destination
- exmem_val  input  WIDTH  EX/MEM result
- memwb_wen  input  1  MEM/WB instruction writes rd
- memwb_rd  input  REGW  MEM/WB destination
- memwb_val  input  WIDTH  MEM/WB result
- out_valid  output  1  alu_* hold a live instruction
- out_ready  input  1  EX consumes this cycle
- alu_a  output  WIDTH  adder operand a
- alu_b  output  WIDTH  adder operand b
- alu_ctrl  output  1  adder ctrl (= latched sub)
- out_rd  output  REGW  destination passed to EX

Behaviour:
- Reset (synchronous): out_valid=0; all stored fields (rs1, rs2, rd, rs1_val, rs2_val, imm, use_imm, sub) = 0. Hence alu_a=alu_b=0, alu_ctrl=0, out_rd=0.
- in_ready = !out_valid || out_ready (combinational). Transfer occurs when in_valid && in_ready.
- Update rule, every clock edge:
  - reset: clear everything.
  - else flush: out_valid<=0; incoming instruction dropped even if transfer would occur.
  - else transfer: latch all in_* fields; out_valid<=1.
  - else out_valid && out_ready: out_valid<=0 (bubble).
  - else hold: keep the instruction. stored rs1_val/rs2_val <= their forwarded value from this cycle (refresh), so a producer retiring during a stall is not lost.
- Forwarding, combinational, per source s in {rs1, rs2}:
  - fwd_s = exmem_val if exmem_wen && exmem_rd==s && s!=0
  - else memwb_val if memwb_wen && memwb_rd==s && s!=0
  - else stored value. EX/MEM has priority.
- Operand mapping:
  - alu_a = fwd_rs1.
  - alu_b = imm if use_imm, else fwd_rs2.
  - alu_ctrl = sub.
  - out_rd = stored rd.
- Latency: one cycle ID→EX. Full throughput when out_ready=1.
- alu_* values are don't-care when out_valid=0, but must remain deterministic (driven by stored fields).
- x0 is never forwarded. A read of x0 yields the stored value, which the register file supplies as 0.
- Flush and reset mid-hold: the instruction is discarded. No partial state survives.

Optional Feature:
- Macro: ALU_FWD_EN.
- Defined: forwarding and hold-refresh as above.
- Undefined: fwd_s = stored value always, no refresh. Exmem_*/memwb_* inputs are ignored (an external hazard unit stalls instead). Handshake is unchanged.

Test Plan:
- Reset then idle: reset=1 for 2 cycles → out_valid=0, alu_a=0, alu_b=0, alu_ctrl=0, in_ready=1.
- Plain ADD: rs1_val=5, rs2_val=7, sub=0, out_ready=1 → next cycle out_valid=1, alu_a=5, alu_b=7, alu_ctrl=0. I-type: use_imm=1, imm=0xFFFFFFFC → alu_b=0xFFFFFFFC.
- Forward priority (ALU_FWD_EN): rs1=3, stored 1; exmem_rd=3, val=0x10; memwb_rd=3, val=0x20 → alu_a=0x10. Drop exmem_wen → alu_a=0x20. rs1=0 with exmem_rd=0 → alu_a=stored value.
- Stall refresh: out_ready=0 for 3 cycles, memwb forwards 0xAB to rs2 only in cycle 1 → in_ready=0, alu_b=0xAB in all later hold cycles. Instruction unchanged until out_ready=1.
- Flush: held instruction plus in_valid=1 with flush=1 → next cycle out_valid=0. Following in_valid instruction accepted normally.
- Back-to-back SUB stream: out_ready=1, 4 instructions (a=9,b=4,sub=1 ...) → one result per cycle, alu_ctrl=1 tracking each, no bubbles.
